// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel clock-enable generator behind the PLL.
// Holds every output off while the PLL settles. After that, each channel
// produces a divided square wave and a one-cycle tick at the end of each
// period. A divisor written at runtime takes effect only at a period
// boundary, or at once on resync, so no pulse is ever truncated or stretched.
module clk_tick_gen #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 20,
    parameter int LOCK_CYCLES = 64,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cfg_valid,
    input  logic [CH_W-1:0]     i_cfg_ch,
    input  logic [DIV_W-1:0]    i_cfg_div,
    output logic                o_cfg_ready,
    output logic                o_cfg_err,
    input  logic                i_resync,
    output logic                o_lock,
    output logic [CHANNELS-1:0] o_tick,
    output logic [CHANNELS-1:0] o_clkout
);

    // Lock counter only has to reach LOCK_CYCLES-1. It then holds there.
    localparam int                LCNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);

    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W:0]    HALF_ONE  = (DIV_W+1)'(1);

    // Channel index limit is one bit wider than the index itself.
    // This keeps the out-of-range test meaningful when CHANNELS is a power of two.
    localparam logic [CH_W:0]     CH_LIMIT  = (CH_W+1)'(CHANNELS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                r_lock;
    logic [LCNT_W-1:0]   r_lock_cnt;
    logic                r_cfg_err;

    logic [DIV_W-1:0]    r_cnt      [CHANNELS];
    logic [DIV_W-1:0]    r_div      [CHANNELS];
    logic [DIV_W-1:0]    r_pend_div [CHANNELS];
    logic [CHANNELS-1:0] r_pend;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                w_cfg_accept;
    logic                w_cfg_ok;
    logic [CHANNELS-1:0] w_wr_hit;
    logic [CHANNELS-1:0] w_wrap;
    logic [CHANNELS-1:0] w_tick;
    logic [CHANNELS-1:0] w_clkout;
    logic [DIV_W:0]      w_half     [CHANNELS];

    // Decode write acceptance, period end and outputs from registered state.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_cfg_accept = i_cfg_valid && r_lock;
        w_cfg_ok     = w_cfg_accept
                       && ({1'b0, i_cfg_ch} < CH_LIMIT)
                       && (i_cfg_div != '0);
        w_wr_hit     = '0;
        w_wrap       = '0;
        w_tick       = '0;
        w_clkout     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_half[i]   = ({1'b0, r_div[i]} + HALF_ONE) >> 1;
            w_wr_hit[i] = w_cfg_ok && (i_cfg_ch == CH_W'(i));
            w_wrap[i]   = (r_cnt[i] == (r_div[i] - DIV_ONE));
            w_tick[i]   = r_lock && w_wrap[i];
            w_clkout[i] = r_lock && ({1'b0, r_cnt[i]} < w_half[i]);
        end
    end

    // Lock-settling counter and the registered write-error pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lock     <= 1'b0;
            r_lock_cnt <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // flop samples the pre-edge values regardless of statement order.
            r_cfg_err <= w_cfg_accept && !w_cfg_ok;
            if (!r_lock) begin
                if (r_lock_cnt == LOCK_LAST) begin
                    r_lock <= 1'b1;
                end else begin
                    r_lock_cnt <= r_lock_cnt + LCNT_ONE;
                end
            end
        end
    end

    // Per-channel counters, active divisors and pending divisors.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: these arrays are small flop banks, not RAM.
            // Reset every entry so a write before lock can never expose stale data.
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i]      <= '0;
                r_div[i]      <= DIV_RST;
                r_pend_div[i] <= DIV_RST;
            end
            r_pend <= '0;
        end else if (r_lock) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (i_resync) begin
                    // Realign to phase 0. A same-cycle write has priority over
                    // an older pending value.
                    r_cnt[i] <= '0;
                    if (w_wr_hit[i]) begin
                        r_div[i] <= i_cfg_div;
                    end else if (r_pend[i]) begin
                        r_div[i] <= r_pend_div[i];
                    end
                    r_pend[i] <= 1'b0;
                end else begin
                    if (w_wrap[i]) begin
                        r_cnt[i] <= '0;
                        if (r_pend[i]) begin
                            r_div[i] <= r_pend_div[i];
                        end
                    end else begin
                        r_cnt[i] <= r_cnt[i] + DIV_ONE;
                    end
                    // A write on the apply edge becomes the next pending value.
                    if (w_wr_hit[i]) begin
                        r_pend_div[i] <= i_cfg_div;
                        r_pend[i]     <= 1'b1;
                    end else if (w_wrap[i]) begin
                        r_pend[i]     <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_lock      = r_lock;
    assign o_cfg_ready = r_lock;
    assign o_cfg_err   = r_cfg_err;
    assign o_tick      = w_tick;
    assign o_clkout    = w_clkout;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Self-checking bench for clk_tick_gen.
// A behavioural model predicts the outputs after every clock edge. The
// prediction is queued when the stimulus is driven, then popped and compared
// on the following falling edge. Each scenario task also measures periods,
// duty cycles and latencies directly against fixed expected numbers.
module tb_clk_tick_gen;

    localparam int CHANNELS    = 3;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 20;
    localparam int LOCK_CYCLES = 8;
    localparam int CH_W        = 2;

    logic                clk       = 1'b0;
    logic                rst       = 1'b1;
    logic                cfg_valid = 1'b0;
    logic [CH_W-1:0]     cfg_ch    = '0;
    logic [DIV_W-1:0]    cfg_div   = '0;
    logic                resync    = 1'b0;
    logic                cfg_ready;
    logic                cfg_err;
    logic                lock;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] clkout;

    clk_tick_gen #(
        .CHANNELS    (CHANNELS),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .LOCK_CYCLES (LOCK_CYCLES),
        .CH_W        (CH_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_valid (cfg_valid),
        .i_cfg_ch    (cfg_ch),
        .i_cfg_div   (cfg_div),
        .o_cfg_ready (cfg_ready),
        .o_cfg_err   (cfg_err),
        .i_resync    (resync),
        .o_lock      (lock),
        .o_tick      (tick),
        .o_clkout    (clkout)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic                lock;
        logic                ready;
        logic                err;
        logic [CHANNELS-1:0] tick;
        logic [CHANNELS-1:0] clkout;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t mon_a;

    // Behavioural model state
    int m_edges;
    bit m_lock;
    bit m_err;
    int m_cnt  [CHANNELS];
    int m_div  [CHANNELS];
    int m_pend [CHANNELS];
    bit m_pflag[CHANNELS];

    task automatic model_reset();
        m_edges = 0;
        m_lock  = 1'b0;
        m_err   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            m_cnt[i]   = 0;
            m_div[i]   = DEFAULT_DIV;
            m_pend[i]  = 0;
            m_pflag[i] = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the inputs as currently driven.
    task automatic model_edge();
        bit acc;
        bit ok;
        bit hit;
        if (rst) begin
            model_reset();
            return;
        end
        acc   = cfg_valid && m_lock;
        ok    = acc && (int'(cfg_ch) < CHANNELS) && (cfg_div != 0);
        m_err = acc && !ok;
        if (m_lock) begin
            for (int i = 0; i < CHANNELS; i++) begin
                hit = ok && (int'(cfg_ch) == i);
                if (resync) begin
                    if (hit)           m_div[i] = int'(cfg_div);
                    else if (m_pflag[i]) m_div[i] = m_pend[i];
                    m_pflag[i] = 1'b0;
                    m_cnt[i]   = 0;
                end else if (m_cnt[i] == m_div[i] - 1) begin
                    if (m_pflag[i]) m_div[i] = m_pend[i];
                    m_pflag[i] = hit;
                    if (hit) m_pend[i] = int'(cfg_div);
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                    if (hit) begin
                        m_pend[i]  = int'(cfg_div);
                        m_pflag[i] = 1'b1;
                    end
                end
            end
        end else begin
            m_edges = m_edges + 1;
            if (m_edges == LOCK_CYCLES) m_lock = 1'b1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.lock  = m_lock;
        e.ready = m_lock;
        e.err   = m_err;
        for (int i = 0; i < CHANNELS; i++) begin
            e.tick[i]   = m_lock && (m_cnt[i] == m_div[i] - 1);
            e.clkout[i] = m_lock && (m_cnt[i] < (m_div[i] + 1) / 2);
        end
        return e;
    endfunction

    // One clock: queue the predicted post-edge outputs, then let the edge happen.
    task automatic step();
        model_edge();
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: compare the oldest prediction on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_a = {lock, cfg_ready, cfg_err, tick, clkout};
            vectors++;
            if (mon_a !== mon_e) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t got lock/rdy/err/tick/clkout=%b required %b",
                         $time, mon_a, mon_e);
            end
        end
    end

    task automatic drive_write(input int ch, input int div);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(div);
        step();
        cfg_valid = 1'b0;
    endtask

    // Clock until tick[ch] is high, bounded. Returns the number of edges taken.
    task automatic wait_tick(input int ch, output int n);
        n = 0;
        while (tick[ch] !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (lock !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    // Count ticks and clkout-high cycles of one channel over a window.
    task automatic measure(input int ch, input int ncyc, output int ticks, output int highs);
        ticks = 0;
        highs = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (tick[ch] === 1'b1)   ticks++;
            if (clkout[ch] === 1'b1) highs++;
            step();
        end
    endtask

    task automatic expect_int(input string name, input int got, input int req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        int n;
        int t;
        int h;
        model_reset();
        step();
        step();
        vectors++;
        if ({lock, cfg_ready, cfg_err, tick, clkout} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b required 0", {lock, cfg_ready, cfg_err, tick, clkout});
        end
        rst = 1'b0;
        wait_lock(n);
        expect_int("lock_latency", n, LOCK_CYCLES);
        vectors++;
        if (clkout !== 3'b111) begin
            miscompares++;
            $display("FAIL first_lock_clkout got %b required 111", clkout);
        end
        measure(0, 20, t, h);
        expect_int("default_ticks", t, 1);
        expect_int("default_highs", h, 10);
    endtask

    task automatic test_mid_write();
        int n;
        int t;
        int h;
        for (int k = 0; k < 5; k++) step();
        drive_write(1, 5);
        wait_tick(1, n);
        expect_int("ch1_finish_old_period", n, 13);
        step();
        measure(1, 10, t, h);
        expect_int("ch1_div5_ticks", t, 2);
        expect_int("ch1_div5_highs", h, 6);
    endtask

    task automatic test_div1();
        int n;
        drive_write(0, 1);
        wait_tick(0, n);
        expect_int("ch0_wait_apply", n, 8);
        step();
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (tick[0] !== 1'b1 || clkout[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL div1_cycle%0d got tick=%b clkout=%b required 1/1", k, tick[0], clkout[0]);
            end
            step();
        end
    endtask

    task automatic test_errors();
        int t;
        int h;
        drive_write(1, 0);
        expect_int("err_div0_pulse", int'(cfg_err), 1);
        step();
        expect_int("err_div0_clear", int'(cfg_err), 0);
        drive_write(3, 7);
        expect_int("err_badch_pulse", int'(cfg_err), 1);
        step();
        expect_int("err_badch_clear", int'(cfg_err), 0);
        measure(1, 10, t, h);
        expect_int("ch1_unchanged_ticks", t, 2);
    endtask

    task automatic test_overwrite();
        int n;
        int t;
        int h;
        wait_tick(2, n);
        step();
        drive_write(2, 7);
        step();
        step();
        drive_write(2, 9);
        wait_tick(2, n);
        step();
        measure(2, 18, t, h);
        expect_int("ch2_div9_ticks", t, 2);
        expect_int("ch2_div9_highs", h, 10);
    endtask

    task automatic test_resync();
        int t;
        int h;
        drive_write(0, 20);
        step();
        for (int k = 0; k < 3; k++) step();
        drive_write(0, 4);
        step();
        step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        vectors++;
        if (clkout !== 3'b111 || tick !== 3'b000) begin
            miscompares++;
            $display("FAIL resync_align got clkout=%b tick=%b required 111/000", clkout, tick);
        end
        measure(0, 8, t, h);
        expect_int("ch0_div4_ticks", t, 2);
        expect_int("ch0_div4_highs", h, 4);
        // Resync together with a same-cycle write
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 16'd6;
        resync    = 1'b1;
        step();
        cfg_valid = 1'b0;
        resync    = 1'b0;
        vectors++;
        if (clkout !== 3'b111) begin
            miscompares++;
            $display("FAIL resync_write_align got clkout=%b required 111", clkout);
        end
        measure(1, 12, t, h);
        expect_int("ch1_div6_ticks", t, 2);
        expect_int("ch1_div6_highs", h, 6);
    endtask

    task automatic test_back_to_back();
        int n;
        wait_tick(2, n);
        step();
        drive_write(2, 6);
        wait_tick(2, n);
        drive_write(2, 3);
        wait_tick(2, n);
        expect_int("ch2_applied_old_pending", n, 5);
        step();
        wait_tick(2, n);
        expect_int("ch2_new_pending_next", n, 2);
    endtask

    task automatic test_async_reset();
        int n;
        int t;
        int h;
        for (int k = 0; k < 3; k++) step();
        #6;
        rst = 1'b1;
        #1;
        vectors++;
        if ({lock, cfg_ready, tick, clkout} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got lock/rdy/tick/clkout=%b required 0", {lock, cfg_ready, tick, clkout});
        end
        model_reset();
        step();
        rst = 1'b0;
        wait_lock(n);
        expect_int("relock_latency", n, LOCK_CYCLES);
        measure(1, 20, t, h);
        expect_int("ch1_default_ticks", t, 1);
        expect_int("ch1_default_highs", h, 10);
    endtask

    initial begin
        test_reset();
        test_mid_write();
        test_div1();
        test_errors();
        test_overwrite();
        test_resync();
        test_back_to_back();
        test_async_reset();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
